// File: rtl/fitness_pkg.sv
// Shared definitions for the fitness evaluation controller: the controller
// FSM state encoding and the default widths used by the controller and the
// fitness evaluator it drives.
package fitness_pkg;

    localparam int unsigned DEF_NUM_PARTICLE_TYPE = 32'd3;
    localparam int unsigned DEF_DATA_WIDTH        = 32'd4;
    localparam int unsigned DEF_INDIVIDUAL_LENGTH = 32'd22;
    localparam int unsigned DEF_SELF_FIT_LENGTH   = 32'd10;
    localparam int unsigned DEF_POP_SIZE          = 32'd50;
    localparam int unsigned DEF_IDX_WIDTH         = 32'd8;
    localparam int unsigned DEF_EVAL_LAT          = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_SE = 3'd1,
        ST_LOAD_IE = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } fsm_state_e;

endpackage

// File: rtl/fitness_eval_ctrl.sv
// Fitness evaluation pass controller.
// Optionally reloads the evaluator energy tables (self energies, then the
// row-major interaction matrix), streams every individual of the population
// into the evaluator at one per cycle, and writes each returned total energy
// into the fitness memory. Ends each pass with a one-cycle done_o pulse.
// Optional feature: define FITNESS_EVAL_CTRL_BEST_TRACK_EN to add
// best_energy_o / best_idx_o, the lowest result of the current pass
// (ties keep the lower index).
module fitness_eval_ctrl
    import fitness_pkg::*;
#(
    parameter int unsigned NUM_PARTICLE_TYPE = DEF_NUM_PARTICLE_TYPE,
    parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int unsigned INDIVIDUAL_LENGTH = DEF_INDIVIDUAL_LENGTH,
    parameter int unsigned SELF_FIT_LENGTH   = DEF_SELF_FIT_LENGTH,
    parameter int unsigned POP_SIZE          = DEF_POP_SIZE,
    parameter int unsigned IDX_WIDTH         = DEF_IDX_WIDTH,
    parameter int unsigned EVAL_LAT          = DEF_EVAL_LAT
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic                         load_cfg_i,
    input  logic                         cfg_valid_i,
    input  logic [DATA_WIDTH-1:0]        cfg_data_i,
    output logic                         cfg_ready_o,
    input  logic                         hold_i,
    output logic                         pop_rd_en_o,
    output logic [IDX_WIDTH-1:0]         pop_rd_addr_o,
    input  logic [INDIVIDUAL_LENGTH-1:0] pop_rd_data_i,
    output logic                         eval_wr_se_valid_o,
    output logic                         eval_wr_ie_valid_o,
    output logic [DATA_WIDTH-1:0]        eval_energy_o,
    output logic                         eval_in_valid_o,
    output logic [INDIVIDUAL_LENGTH-1:0] eval_ind_vec_o,
    output logic [IDX_WIDTH-1:0]         eval_ind_idx_o,
    input  logic                         eval_out_valid_i,
    input  logic [SELF_FIT_LENGTH-1:0]   eval_total_energy_i,
    input  logic [IDX_WIDTH-1:0]         eval_ind_idx_i,
    output logic                         fit_wr_en_o,
    output logic [IDX_WIDTH-1:0]         fit_wr_addr_o,
    output logic [SELF_FIT_LENGTH-1:0]   fit_wr_data_o,
    output logic                         busy_o,
`ifdef FITNESS_EVAL_CTRL_BEST_TRACK_EN
    output logic [SELF_FIT_LENGTH-1:0]   best_energy_o,
    output logic [IDX_WIDTH-1:0]         best_idx_o,
`endif
    output logic                         done_o
);

    localparam int unsigned SE_BEATS  = NUM_PARTICLE_TYPE;
    localparam int unsigned IE_BEATS  = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE;
    localparam int unsigned CFG_CNT_W = $clog2(IE_BEATS + 1);
    localparam int unsigned RES_CNT_W = IDX_WIDTH + 1;

    fsm_state_e                 state_q;
    logic [CFG_CNT_W-1:0]       cfg_cnt_q;
    logic [IDX_WIDTH-1:0]       issue_cnt_q;
    logic [RES_CNT_W-1:0]       res_cnt_q;
    logic                       in_valid_q;
    logic [IDX_WIDTH-1:0]       ind_idx_q;
    logic                       busy_q;
    logic                       done_q;

    logic                       load_se_s;
    logic                       load_ie_s;
    logic                       cfg_beat_s;
    logic                       strobe_s;

    assign load_se_s  = (state_q == ST_LOAD_SE);
    assign load_ie_s  = (state_q == ST_LOAD_IE);
    assign cfg_beat_s = (load_se_s || load_ie_s) && cfg_valid_i;
    // hold_i only gates new reads; anything already in flight completes.
    assign strobe_s   = (state_q == ST_ISSUE) && !hold_i;

    // Energy words go straight through to the evaluator in the accepting cycle.
    assign cfg_ready_o        = load_se_s || load_ie_s;
    assign eval_wr_se_valid_o = load_se_s && cfg_valid_i;
    assign eval_wr_ie_valid_o = load_ie_s && cfg_valid_i;
    assign eval_energy_o      = cfg_beat_s ? cfg_data_i : {DATA_WIDTH{1'b0}};

    assign pop_rd_en_o    = strobe_s;
    assign pop_rd_addr_o  = issue_cnt_q;

    // Read data lands one cycle after the strobe, aligned with in_valid_q.
    assign eval_in_valid_o = in_valid_q;
    assign eval_ind_idx_o  = ind_idx_q;
    assign eval_ind_vec_o  = in_valid_q ? pop_rd_data_i : {INDIVIDUAL_LENGTH{1'b0}};

    // Results are written back in the cycle they arrive, in any state.
    assign fit_wr_en_o   = eval_out_valid_i;
    assign fit_wr_addr_o = eval_out_valid_i ? eval_ind_idx_i : {IDX_WIDTH{1'b0}};
    assign fit_wr_data_o = eval_out_valid_i ? eval_total_energy_i : {SELF_FIT_LENGTH{1'b0}};

    assign busy_o = busy_q;
    assign done_o = done_q;

    // Pass sequencing FSM with its counters and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cfg_cnt_q   <= {CFG_CNT_W{1'b0}};
            issue_cnt_q <= {IDX_WIDTH{1'b0}};
            res_cnt_q   <= {RES_CNT_W{1'b0}};
            in_valid_q  <= 1'b0;
            ind_idx_q   <= {IDX_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            in_valid_q <= strobe_s;
            ind_idx_q  <= strobe_s ? issue_cnt_q : {IDX_WIDTH{1'b0}};
            if (eval_out_valid_i) begin
                res_cnt_q <= res_cnt_q + RES_CNT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        busy_q    <= 1'b1;
                        cfg_cnt_q <= {CFG_CNT_W{1'b0}};
                        state_q   <= load_cfg_i ? ST_LOAD_SE : ST_ISSUE;
                    end
                end
                ST_LOAD_SE: begin
                    if (cfg_valid_i) begin
                        if (cfg_cnt_q == CFG_CNT_W'(SE_BEATS - 1)) begin
                            cfg_cnt_q <= {CFG_CNT_W{1'b0}};
                            state_q   <= ST_LOAD_IE;
                        end else begin
                            cfg_cnt_q <= cfg_cnt_q + CFG_CNT_W'(1);
                        end
                    end
                end
                ST_LOAD_IE: begin
                    if (cfg_valid_i) begin
                        if (cfg_cnt_q == CFG_CNT_W'(IE_BEATS - 1)) begin
                            cfg_cnt_q <= {CFG_CNT_W{1'b0}};
                            state_q   <= ST_ISSUE;
                        end else begin
                            cfg_cnt_q <= cfg_cnt_q + CFG_CNT_W'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (strobe_s) begin
                        issue_cnt_q <= issue_cnt_q + IDX_WIDTH'(1);
                        if (issue_cnt_q == IDX_WIDTH'(POP_SIZE - 1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (res_cnt_q >= RES_CNT_W'(POP_SIZE)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    issue_cnt_q <= {IDX_WIDTH{1'b0}};
                    res_cnt_q   <= {RES_CNT_W{1'b0}};
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FITNESS_EVAL_CTRL_BEST_TRACK_EN
    logic [SELF_FIT_LENGTH-1:0] best_energy_q;
    logic [IDX_WIDTH-1:0]       best_idx_q;
    logic                       better_s;

    // Strictly lower energy wins; on equal energy only a lower index wins.
    assign better_s = eval_out_valid_i &&
                      ((eval_total_energy_i < best_energy_q) ||
                       ((eval_total_energy_i == best_energy_q) && (eval_ind_idx_i < best_idx_q)));

    assign best_energy_o = best_energy_q;
    assign best_idx_o    = best_idx_q;

    // Track the minimum result of the pass; an accepted start restarts the search.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            best_energy_q <= {SELF_FIT_LENGTH{1'b1}};
            best_idx_q    <= {IDX_WIDTH{1'b0}};
        end else if ((state_q == ST_IDLE) && start_i) begin
            best_energy_q <= {SELF_FIT_LENGTH{1'b1}};
            best_idx_q    <= {IDX_WIDTH{1'b0}};
        end else if (better_s) begin
            best_energy_q <= eval_total_energy_i;
            best_idx_q    <= eval_ind_idx_i;
        end
    end
`endif

endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// Self-checking bench for fitness_eval_ctrl with a population memory model,
// a fixed-latency evaluator model (energy = low bits of the individual) and
// a monitor that records what the controller does.
module tb_fitness_eval_ctrl;

    localparam int NPT = 3;
    localparam int DW  = 4;
    localparam int IL  = 22;
    localparam int SFL = 10;
    localparam int POP = 50;
    localparam int IW  = 8;
    localparam int LAT = 4;
    localparam int NONE = 100000;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic           rst_n = 1'b0;
    logic           start_i = 1'b0;
    logic           load_cfg_i = 1'b0;
    logic           cfg_valid_i = 1'b0;
    logic [DW-1:0]  cfg_data_i = '0;
    logic           cfg_ready_o;
    logic           hold_i = 1'b0;
    logic           pop_rd_en_o;
    logic [IW-1:0]  pop_rd_addr_o;
    logic [IL-1:0]  pop_rd_data_i;
    logic           eval_wr_se_valid_o;
    logic           eval_wr_ie_valid_o;
    logic [DW-1:0]  eval_energy_o;
    logic           eval_in_valid_o;
    logic [IL-1:0]  eval_ind_vec_o;
    logic [IW-1:0]  eval_ind_idx_o;
    logic           eval_out_valid_i;
    logic [SFL-1:0] eval_total_energy_i;
    logic [IW-1:0]  eval_ind_idx_i;
    logic           fit_wr_en_o;
    logic [IW-1:0]  fit_wr_addr_o;
    logic [SFL-1:0] fit_wr_data_o;
    logic           busy_o;
    logic           done_o;
`ifdef FITNESS_EVAL_CTRL_BEST_TRACK_EN
    logic [SFL-1:0] best_energy_o;
    logic [IW-1:0]  best_idx_o;
`endif

    fitness_eval_ctrl dut (
        .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .load_cfg_i(load_cfg_i),
        .cfg_valid_i(cfg_valid_i), .cfg_data_i(cfg_data_i), .cfg_ready_o(cfg_ready_o),
        .hold_i(hold_i), .pop_rd_en_o(pop_rd_en_o), .pop_rd_addr_o(pop_rd_addr_o),
        .pop_rd_data_i(pop_rd_data_i), .eval_wr_se_valid_o(eval_wr_se_valid_o),
        .eval_wr_ie_valid_o(eval_wr_ie_valid_o), .eval_energy_o(eval_energy_o),
        .eval_in_valid_o(eval_in_valid_o), .eval_ind_vec_o(eval_ind_vec_o),
        .eval_ind_idx_o(eval_ind_idx_o), .eval_out_valid_i(eval_out_valid_i),
        .eval_total_energy_i(eval_total_energy_i), .eval_ind_idx_i(eval_ind_idx_i),
        .fit_wr_en_o(fit_wr_en_o), .fit_wr_addr_o(fit_wr_addr_o),
        .fit_wr_data_o(fit_wr_data_o), .busy_o(busy_o),
`ifdef FITNESS_EVAL_CTRL_BEST_TRACK_EN
        .best_energy_o(best_energy_o), .best_idx_o(best_idx_o),
`endif
        .done_o(done_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Population memory: one-cycle read latency, junk when not read.
    logic [IL-1:0] mem [POP];
    always @(posedge clk_i) begin
        if (!rst_n) pop_rd_data_i <= '0;
        else if (pop_rd_en_o) pop_rd_data_i <= mem[pop_rd_addr_o];
        else pop_rd_data_i <= IL'($urandom);
    end

    // Evaluator: LAT-cycle pipeline, result = low SFL bits of the individual.
    logic           ev_v [LAT];
    logic [IW-1:0]  ev_i [LAT];
    logic [SFL-1:0] ev_e [LAT];
    always @(posedge clk_i) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                ev_v[i] <= 1'b0; ev_i[i] <= '0; ev_e[i] <= '0;
            end
        end else begin
            ev_v[0] <= eval_in_valid_o;
            ev_i[0] <= eval_ind_idx_o;
            ev_e[0] <= eval_ind_vec_o[SFL-1:0];
            for (int i = 1; i < LAT; i++) begin
                ev_v[i] <= ev_v[i-1]; ev_i[i] <= ev_i[i-1]; ev_e[i] <= ev_e[i-1];
            end
        end
    end
    assign eval_out_valid_i    = ev_v[LAT-1];
    assign eval_ind_idx_i      = ev_i[LAT-1];
    assign eval_total_energy_i = ev_e[LAT-1];

    // Monitor, sampled on the falling edge.
    int strobe_q[$];
    int strobe_cyc_q[$];
    int se_q[$];
    int ie_q[$];
    int fit_cnt [POP];
    int fit_val [POP];
    int fit_bad_addr = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int cfg_ready_cnt = 0;

    always @(negedge clk_i) begin
        if (rst_n) begin
            if (pop_rd_en_o) begin
                strobe_q.push_back(int'(pop_rd_addr_o));
                strobe_cyc_q.push_back(cyc);
            end
            if (fit_wr_en_o) begin
                if (int'(fit_wr_addr_o) < POP) begin
                    fit_cnt[fit_wr_addr_o] <= fit_cnt[fit_wr_addr_o] + 1;
                    fit_val[fit_wr_addr_o] <= int'(fit_wr_data_o);
                end else begin
                    fit_bad_addr <= fit_bad_addr + 1;
                end
            end
            if (eval_wr_se_valid_o) se_q.push_back(int'(eval_energy_o));
            if (eval_wr_ie_valid_o) ie_q.push_back(int'(eval_energy_o));
            if (cfg_ready_o) cfg_ready_cnt <= cfg_ready_cnt + 1;
            if (done_o) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic clear_obs();
        strobe_q.delete(); strobe_cyc_q.delete(); se_q.delete(); ie_q.delete();
        for (int a = 0; a < POP; a++) begin fit_cnt[a] = 0; fit_val[a] = -1; end
        fit_bad_addr = 0; done_cnt = 0; done_cyc = 0; cfg_ready_cnt = 0;
    endtask

    task automatic fill_mem_random();
        for (int a = 0; a < POP; a++) mem[a] = IL'($urandom);
    endtask

    // Number of strobes that do not follow the expected 0,1,2,... order.
    function automatic int seq_errs();
        int n = 0;
        for (int i = 0; i < strobe_q.size(); i++) if (strobe_q[i] != i) n++;
        return n;
    endfunction

    // Number of population slots not written exactly once with energy(mem[a]).
    function automatic int fit_errs();
        int n = fit_bad_addr;
        for (int a = 0; a < POP; a++)
            if (fit_cnt[a] != 1 || fit_val[a] != int'(mem[a][SFL-1:0])) n++;
        return n;
    endfunction

    task automatic drive_start(input bit load);
        clear_obs();
        @(posedge clk_i); #1;
        start_cyc = cyc; start_i = 1'b1; load_cfg_i = load;
        @(posedge clk_i); #1;
        start_i = 1'b0; load_cfg_i = 1'b0;
    endtask

    task automatic send_beat(input int val);
        int gap = $urandom_range(0, 2);
        repeat (gap) begin
            cfg_valid_i = 1'b0; cfg_data_i = DW'($urandom);
            @(posedge clk_i); #1;
        end
        cfg_valid_i = 1'b1; cfg_data_i = DW'(val);
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
    endtask

    // Run until done_o, with optional hold window and a stray start/cfg beat.
    task automatic wait_done(input int hold_lo, input int hold_hi, input int inject_k);
        int k;
        while (done_cnt == 0 && (cyc - start_cyc) < 400) begin
            k = cyc - start_cyc;
            hold_i = (k >= hold_lo && k <= hold_hi);
            if (k == inject_k) begin
                start_i = 1'b1; load_cfg_i = 1'b1; cfg_valid_i = 1'b1; cfg_data_i = 4'hA;
            end else begin
                start_i = 1'b0; load_cfg_i = 1'b0; cfg_valid_i = 1'b0;
            end
            @(posedge clk_i); #1;
        end
        hold_i = 1'b0; start_i = 1'b0; load_cfg_i = 1'b0; cfg_valid_i = 1'b0;
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: no done_o within 400 cycles of start");
        end
        repeat (3) begin @(posedge clk_i); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({cfg_ready_o, pop_rd_en_o, pop_rd_addr_o, eval_wr_se_valid_o, eval_wr_ie_valid_o,
             eval_energy_o, eval_in_valid_o, eval_ind_vec_o, eval_ind_idx_o, fit_wr_en_o,
             fit_wr_addr_o, fit_wr_data_o, busy_o, done_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs (busy=%0b done=%0b) required all 0", busy_o, done_o);
        end
`ifdef FITNESS_EVAL_CTRL_BEST_TRACK_EN
        checks++;
        if (best_energy_o !== {SFL{1'b1}} || best_idx_o !== '0) begin
            errors++;
            $display("FAIL reset_best: got %0d/%0d required %0d/0", best_energy_o, best_idx_o, (1 << SFL) - 1);
        end
`endif
        @(posedge clk_i); #1; rst_n = 1'b1;
        repeat (2) begin @(posedge clk_i); #1; end
    endtask

    task automatic test_load_pass();
        int bad;
        fill_mem_random();
        drive_start(1'b1);
        for (int i = 1; i <= NPT; i++) send_beat(i);
        for (int i = 0; i < NPT * NPT; i++) send_beat(i);
        wait_done(NONE, NONE, -1);
        checks++;
        if (se_q.size() != NPT) begin
            errors++; $display("FAIL load_se_count: got %0d required %0d", se_q.size(), NPT);
        end
        bad = 0;
        for (int i = 0; i < se_q.size(); i++) if (se_q[i] != i + 1) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL load_se_values: got %0d wrong words required 0", bad);
        end
        checks++;
        if (ie_q.size() != NPT * NPT) begin
            errors++; $display("FAIL load_ie_count: got %0d required %0d", ie_q.size(), NPT * NPT);
        end
        bad = 0;
        for (int i = 0; i < ie_q.size(); i++) if (ie_q[i] != i) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL load_ie_values: got %0d wrong words required 0", bad);
        end
        checks++;
        if (strobe_q.size() != POP || seq_errs() != 0) begin
            errors++; $display("FAIL load_issue: got %0d strobes, %0d out of order, required %0d in order", strobe_q.size(), seq_errs(), POP);
        end
        checks++;
        if (fit_errs() != 0) begin
            errors++; $display("FAIL load_fit: got %0d bad slots required 0", fit_errs());
        end
    endtask

    task automatic test_nohold_pass();
        fill_mem_random();
        drive_start(1'b0);
        wait_done(NONE, NONE, -1);
        checks++;
        if (strobe_q.size() != POP || seq_errs() != 0) begin
            errors++; $display("FAIL nohold_issue: got %0d strobes, %0d out of order, required %0d in order", strobe_q.size(), seq_errs(), POP);
        end
        checks++;
        if (strobe_q.size() == POP && strobe_cyc_q[POP-1] - strobe_cyc_q[0] != POP - 1) begin
            errors++; $display("FAIL nohold_rate: got span %0d required %0d", strobe_cyc_q[POP-1] - strobe_cyc_q[0], POP - 1);
        end
        checks++;
        if (fit_errs() != 0) begin
            errors++; $display("FAIL nohold_fit: got %0d bad slots required 0", fit_errs());
        end
        checks++;
        if (done_cnt != 1 || done_cyc - start_cyc != POP + LAT + 3) begin
            errors++; $display("FAIL nohold_latency: got %0d pulses at %0d cycles required 1 at %0d", done_cnt, done_cyc - start_cyc, POP + LAT + 3);
        end
        checks++;
        if (busy_o !== 1'b0 || cfg_ready_cnt != 0) begin
            errors++; $display("FAIL nohold_idle: got busy=%0b cfg_ready_cycles=%0d required 0/0", busy_o, cfg_ready_cnt);
        end
    endtask

    task automatic test_hold();
        int gaps;
        fill_mem_random();
        drive_start(1'b0);
        wait_done(11, 15, -1);
        checks++;
        if (strobe_q.size() != POP || seq_errs() != 0) begin
            errors++; $display("FAIL hold_issue: got %0d strobes, %0d out of order, required %0d in order", strobe_q.size(), seq_errs(), POP);
        end
        gaps = (strobe_q.size() > 0) ? (strobe_cyc_q[strobe_q.size()-1] - strobe_cyc_q[0] + 1 - strobe_q.size()) : -1;
        checks++;
        if (gaps != 5) begin
            errors++; $display("FAIL hold_gap: got %0d idle cycles required 5", gaps);
        end
        checks++;
        if (fit_errs() != 0) begin
            errors++; $display("FAIL hold_fit: got %0d bad slots required 0", fit_errs());
        end
        checks++;
        if (done_cnt != 1 || done_cyc - start_cyc != POP + LAT + 3 + 5) begin
            errors++; $display("FAIL hold_latency: got %0d pulses at %0d cycles required 1 at %0d", done_cnt, done_cyc - start_cyc, POP + LAT + 8);
        end
    endtask

    task automatic test_ignore();
        fill_mem_random();
        drive_start(1'b0);
        wait_done(NONE, NONE, 5);
        checks++;
        if (cfg_ready_cnt != 0 || se_q.size() != 0 || ie_q.size() != 0) begin
            errors++; $display("FAIL ignore_cfg: got ready=%0d se=%0d ie=%0d required 0/0/0", cfg_ready_cnt, se_q.size(), ie_q.size());
        end
        checks++;
        if (strobe_q.size() != POP || seq_errs() != 0 || fit_errs() != 0) begin
            errors++; $display("FAIL ignore_pass: got %0d strobes, %0d bad slots required %0d/0", strobe_q.size(), fit_errs(), POP);
        end
        checks++;
        if (done_cnt != 1 || done_cyc - start_cyc != POP + LAT + 3) begin
            errors++; $display("FAIL ignore_latency: got %0d pulses at %0d cycles required 1 at %0d", done_cnt, done_cyc - start_cyc, POP + LAT + 3);
        end
    endtask

    task automatic test_reset_drain();
        fill_mem_random();
        drive_start(1'b0);
        while (cyc - start_cyc < POP + 3) begin @(posedge clk_i); #1; end
        rst_n = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({cfg_ready_o, pop_rd_en_o, pop_rd_addr_o, eval_wr_se_valid_o, eval_wr_ie_valid_o,
             eval_energy_o, eval_in_valid_o, eval_ind_vec_o, eval_ind_idx_o, fit_wr_en_o,
             fit_wr_addr_o, fit_wr_data_o, busy_o, done_o} !== '0) begin
            errors++;
            $display("FAIL drain_reset_outputs: got nonzero outputs (busy=%0b fit_wr=%0b) required all 0", busy_o, fit_wr_en_o);
        end
        rst_n = 1'b1;
        repeat (30) begin @(posedge clk_i); #1; end
        checks++;
        if (done_cnt != 0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL drain_reset_abandon: got done=%0d busy=%0b required 0/0", done_cnt, busy_o);
        end
    endtask

`ifdef FITNESS_EVAL_CTRL_BEST_TRACK_EN
    task automatic test_best();
        int exp_e, exp_i;
        for (int a = 0; a < POP; a++) begin
            mem[a] = IL'($urandom);
            mem[a][SFL-1:0] = SFL'($urandom_range(100, (1 << SFL) - 2));
        end
        mem[5][SFL-1:0] = SFL'(37);
        mem[20][SFL-1:0] = SFL'(37);
        exp_e = (1 << SFL) - 1; exp_i = 0;
        for (int a = 0; a < POP; a++)
            if (int'(mem[a][SFL-1:0]) < exp_e) begin exp_e = int'(mem[a][SFL-1:0]); exp_i = a; end
        drive_start(1'b0);
        wait_done(NONE, NONE, -1);
        repeat (5) begin @(posedge clk_i); #1; end
        checks++;
        if (int'(best_energy_o) != exp_e || int'(best_idx_o) != exp_i) begin
            errors++; $display("FAIL best_track: got %0d@%0d required %0d@%0d", best_energy_o, best_idx_o, exp_e, exp_i);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_pass();
        test_nohold_pass();
        test_hold();
        test_ignore();
        test_reset_drain();
        test_nohold_pass();
`ifdef FITNESS_EVAL_CTRL_BEST_TRACK_EN
        test_best();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
